// File: rtl/modexp_pkg.sv
// Shared types and helpers for the modular exponentiator.
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MUL  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Edges from the start-accepting edge to done when every exponent bit is processed.
    function automatic int unsigned modexp_latency(input int unsigned width,
                                                   input int unsigned exp_width);
        return width + exp_width * (width + 2) + 1;
    endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: R = A*B*2^-WIDTH mod N, for A, B < N and N odd.
// WIDTH iterations after go, then one final conditional-subtract cycle with fin high.
module mont_mul_serial #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] R,
    output logic             fin
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH+1:0] acc_q, acc_d, sum, sum_n;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             a_bit;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        r_d   = r_q;
        a_bit = (A & (WIDTH'(1) << cnt_q)) != '0;
        sum   = acc_q + (a_bit ? {2'b00, B} : '0);
        // Adding N when odd makes the sum divisible by two; acc stays below 2N.
        sum_n = sum + (sum[0] ? {2'b00, N} : '0);
        fin   = run_q && (cnt_q == CW'(WIDTH));
        if (go) begin
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (fin) begin
            r_d   = (acc_q >= {2'b00, N}) ? acc_q[WIDTH-1:0] - N : acc_q[WIDTH-1:0];
            run_d = 1'b0;
        end else if (run_q) begin
            acc_d = sum_n >> 1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            r_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            r_q   <= r_d;
        end
    end

    assign R = r_q;

endmodule

// File: rtl/modexp_param.sv
// Modular exponentiator S_out = M^d mod N: T is pre-scaled into Montgomery form, then right-to-left
// square-and-multiply. Define MODEXP_EARLY_EXIT_EN to stop after the highest set exponent bit.
module modexp_param
    import modexp_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int EXP_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M_i,
    input  logic [WIDTH-1:0]     N_i,
    input  logic [EXP_WIDTH-1:0] d_i,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     S_out
);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     s_q, s_d, t_q, t_d, n_q, n_d, s_out_q, s_out_d;
    logic [EXP_WIDTH-1:0] d_q, d_d;
    logic [IW-1:0]        i_q, i_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic                 err_q, err_d, done_q, done_d;
    logic                 mm_go, fin_s, fin_t, last_bit, bad_op, dbl_carry;
    logic [WIDTH-1:0]     r_s, r_t, t_dbl;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        t_d       = t_q;
        n_d       = n_q;
        d_d       = d_q;
        i_d       = i_q;
        pre_d     = pre_q;
        err_d     = err_q;
        done_d    = 1'b0;
        s_out_d   = s_out_q;
        mm_go     = 1'b0;
        bad_op    = !N_i[0] || (N_i == WIDTH'(1)) || (M_i >= N_i);
        dbl_carry = t_q[WIDTH-1];
        t_dbl     = {t_q[WIDTH-2:0], 1'b0};
`ifdef MODEXP_EARLY_EXIT_EN
        last_bit  = ((d_q >> i_q) >> 1) == '0;
`else
        last_bit  = (i_q == IW'(EXP_WIDTH - 1));
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d   = N_i;
                    d_d   = d_i;
                    i_d   = '0;
                    pre_d = '0;
                    err_d = bad_op;
                    s_d   = bad_op ? '0 : WIDTH'(1);
                    t_d   = bad_op ? '0 : M_i;
                    state_d = bad_op ? ST_DONE : ST_PRE;
                end
            end
            ST_PRE: begin
                // {carry, t_dbl} is 2T; T < N keeps the result below N after one subtract.
                t_d   = (dbl_carry || t_dbl >= n_q) ? t_dbl - n_q : t_dbl;
                pre_d = pre_q + PW'(1);
                if (pre_q == PW'(WIDTH - 1)) begin
                    state_d = ST_MUL;
                    mm_go   = 1'b1;
                end
            end
            ST_MUL: begin
                if (fin_s && fin_t) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                t_d = r_t;
                if ((d_q & (EXP_WIDTH'(1) << i_q)) != '0) s_d = r_s;
                i_d = i_q + IW'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                    mm_go   = 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                s_out_d = s_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            t_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            i_q     <= '0;
            pre_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            s_out_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            n_q     <= n_d;
            d_q     <= d_d;
            i_q     <= i_d;
            pre_q   <= pre_d;
            err_q   <= err_d;
            done_q  <= done_d;
            s_out_q <= s_out_d;
        end
    end

    // S stays in the normal domain (S*T*R^-1), T stays in the Montgomery domain (T*T*R^-1).
    mont_mul_serial #(.WIDTH(WIDTH)) u_mul_st (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (mm_go),
        .A       (s_q),
        .B       (t_q),
        .N       (n_q),
        .R       (r_s),
        .fin     (fin_s)
    );

    mont_mul_serial #(.WIDTH(WIDTH)) u_mul_tt (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (mm_go),
        .A       (t_q),
        .B       (t_q),
        .N       (n_q),
        .R       (r_t),
        .fin     (fin_t)
    );

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign S_out = s_out_q;

endmodule
